// File: rtl/sdram_testmod.sv
// sdram_testmod: writes WORDS address-tagged patterns to SDRAM, reads them back, reports pass/fail/timeout, error count and first bad address
module sdram_testmod #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int WORDS = 16,
  parameter int ADDR_STEP = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iStart,
  input  logic [1:0]  iDone,
  input  logic [63:0] iData,
  output logic [1:0]  oCall,
  output logic [23:0] oAddr,
  output logic [63:0] oData,
  output logic        oBusy,
  output logic        oPass,
  output logic        oFail,
  output logic        oTimeout,
  output logic [7:0]  oErrCount,
  output logic [23:0] oErrAddr
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] LAST = 8'(WORDS - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  state_t state;
  logic [7:0] k, kn;
  logic [23:0] an;
  logic [WW-1:0] wd;
  logic last, hit;
  function automatic logic [63:0] pat(input logic [23:0] a, input logic [7:0] i);
    return {8'hA5, a, ~a, i};
  endfunction
  always_comb begin
    last = k == LAST;
    kn = last ? 8'd0 : k + 8'd1;
    an = BASE_ADDR + 24'(kn) * 24'(ADDR_STEP);
    hit = (state == WR_REQ) ? iDone[1] : (state == RD_REQ) && iDone[0];
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      k <= '0;
      wd <= '0;
      oCall <= '0;
      oAddr <= '0;
      oData <= '0;
      oBusy <= 1'b0;
      oPass <= 1'b0;
      oFail <= 1'b0;
      oTimeout <= 1'b0;
      oErrCount <= '0;
      oErrAddr <= '0;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          state <= WR_REQ;
          k <= '0;
          wd <= '0;
          oCall <= 2'b10;
          oAddr <= BASE_ADDR;
          oData <= pat(BASE_ADDR, 8'd0);
          oBusy <= 1'b1;
          oPass <= 1'b0;
          oFail <= 1'b0;
          oTimeout <= 1'b0;
          oErrCount <= '0;
          oErrAddr <= '0;
        end
        WR_REQ, RD_REQ: begin
          if (hit) begin
            oCall <= '0;
            state <= (state == WR_REQ) ? WR_GAP : RD_GAP;
            if (state == RD_REQ && iData != oData) begin
              if (oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
              if (oErrCount == 8'd0) oErrAddr <= oAddr;
            end
          end else if (wd == WD_MAX) begin
            oCall <= '0;
            oTimeout <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        WR_GAP: begin
          k <= kn;
          wd <= '0;
          oAddr <= an;
          oData <= pat(an, kn);
          oCall <= last ? 2'b01 : 2'b10;
          state <= last ? RD_REQ : WR_REQ;
        end
        RD_GAP: begin
          if (last) begin
            state <= DONE;
          end else begin
            k <= kn;
            wd <= '0;
            oAddr <= an;
            oData <= pat(an, kn);
            oCall <= 2'b01;
            state <= RD_REQ;
          end
        end
        DONE: begin
          oPass <= oErrCount == 8'd0 && !oTimeout;
          oFail <= oErrCount != 8'd0 || oTimeout;
          oBusy <= 1'b0;
          k <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
